// File: rtl/xy_input_buffer_pkg.sv
// Shared mesh-switch definitions: direction encoding and one-hot helper used by the
// input buffers, packet arbiters and crossbar.
package xy_input_buffer_pkg;

  localparam int unsigned N_DIRS = 5;

  typedef enum logic [2:0] {
    DIR_RESOURCE = 3'd0,
    DIR_WEST     = 3'd1,
    DIR_EAST     = 3'd2,
    DIR_NORTH    = 3'd3,
    DIR_SOUTH    = 3'd4
  } dir_e;

  function automatic logic [N_DIRS-1:0] dir_onehot(input dir_e dir);
    return N_DIRS'(1) << dir;
  endfunction

endpackage

// File: rtl/xy_route_compute.sv
// Combinational XY route: resolve the column first, then the row, else deliver locally.
module xy_route_compute
  import xy_input_buffer_pkg::*;
#(
  parameter int unsigned X_ID       = 0,
  parameter int unsigned Y_ID       = 0,
  parameter int unsigned COL_ADDR_W = 2,
  parameter int unsigned ROW_ADDR_W = 2
) (
  input  logic [COL_ADDR_W-1:0] dst_x_i,
  input  logic [ROW_ADDR_W-1:0] dst_y_i,
  output logic [N_DIRS-1:0]     route_c_o
);

  localparam logic [COL_ADDR_W-1:0] MY_X = COL_ADDR_W'(X_ID);
  localparam logic [ROW_ADDR_W-1:0] MY_Y = ROW_ADDR_W'(Y_ID);

  dir_e dir_c;

  always_comb begin
    dir_c = DIR_RESOURCE;
    if (dst_x_i > MY_X) begin
      dir_c = DIR_EAST;
    end else if (dst_x_i < MY_X) begin
      dir_c = DIR_WEST;
    end else if (dst_y_i < MY_Y) begin
      dir_c = DIR_NORTH;
    end else if (dst_y_i > MY_Y) begin
      dir_c = DIR_SOUTH;
    end
    route_c_o = dir_onehot(dir_c);
  end

endmodule

// File: rtl/xy_input_buffer.sv
// Per-input-port FWFT packet FIFO that XY-routes its head packet into a one-hot
// output-direction request and pops on the crossbar grant.
module xy_input_buffer
  import xy_input_buffer_pkg::*;
#(
  parameter int unsigned X_ID       = 0,
  parameter int unsigned Y_ID       = 0,
  parameter int unsigned COL_ADDR_W = 2,
  parameter int unsigned ROW_ADDR_W = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PACKET_W  = COL_ADDR_W + ROW_ADDR_W + DATA_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PACKET_W-1:0] data_i,
  input  logic                wr_en_i,
  output logic                full_o,
  output logic                drop_o,
  output logic [PACKET_W-1:0] data_o,
  output logic [N_DIRS-1:0]   vld_o,
  input  logic                rd_en_i,
  output logic                empty_o
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned DST_Y_LSB = DATA_W;
  localparam int unsigned DST_X_LSB = DATA_W + ROW_ADDR_W;

  logic [PACKET_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                drop_q, drop_d;

  logic                push_c;
  logic                pop_c;
  logic [PACKET_W-1:0] head_c;
  logic [N_DIRS-1:0]   route_c;

  // Status decodes only from the registered count, keeping full/empty free of input paths.
  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == CNT_W'(0));

  always_comb begin
    push_c   = wr_en_i && !full_o;
    pop_c    = rd_en_i && !empty_o;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    count_d  = count_q;
    drop_d   = wr_en_i && full_o;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is intentionally left unreset; emptiness gates everything read from it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_c) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_c = mem_q[rd_ptr_q];

  xy_route_compute #(
    .X_ID      (X_ID),
    .Y_ID      (Y_ID),
    .COL_ADDR_W(COL_ADDR_W),
    .ROW_ADDR_W(ROW_ADDR_W)
  ) u_route (
    .dst_x_i  (head_c[DST_X_LSB +: COL_ADDR_W]),
    .dst_y_i  (head_c[DST_Y_LSB +: ROW_ADDR_W]),
    .route_c_o(route_c)
  );

  assign data_o = empty_o ? '0 : head_c;
  assign vld_o  = empty_o ? '0 : route_c;
  assign drop_o = drop_q;

endmodule
